// File: rtl/overvoltage_ctrl_pkg.sv
// Shared types and helpers for the overvoltage detector sequencer.
// Holds the state encoding, the trip-code width and a saturating subtract.
package overvoltage_ctrl_pkg;

  localparam int OTRIP_W = 4;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    SETTLE  = 2'd1,
    ARMED   = 2'd2,
    TRIPPED = 2'd3
  } state_e;

  // Lowers a trip code by dec, clamping at zero instead of wrapping.
  function automatic logic [OTRIP_W-1:0] sat_sub(input logic [OTRIP_W-1:0] code,
                                                 input int unsigned dec);
    if (dec >= 32'(code)) return '0;
    return code - OTRIP_W'(dec);
  endfunction

endpackage

// File: rtl/overvoltage_ctrl_sync.sv
// ov_sync_debounce: 2-flop synchroniser for the async comparator output plus
// a consecutive-sample debouncer that flips a level after DEBOUNCE agreeing samples.
module ov_sync_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  input  logic clr,
  input  logic force_low,
  output logic level,
  output logic toggle
);

  localparam int DCW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [DCW-1:0] LAST = DCW'(DEBOUNCE - 1);

  logic [1:0]     sync_q;
  logic           ov_s;
  logic [DCW-1:0] cnt;

  assign ov_s = sync_q[1];

  // The flip is decided combinationally so the parent FSM changes state on the same edge.
  assign toggle = !clr && (ov_s != level) && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_in};

      if (clr || (ov_s == level) || toggle) cnt <= '0;
      else                                  cnt <= cnt + DCW'(1);

      if (force_low)   level <= 1'b0;
      else if (toggle) level <= ov_s;
    end
  end

endmodule

// File: rtl/overvoltage_ctrl.sv
// Sequencer for the overvoltage detector macro: enable, trip code and bias source,
// comparator blanking while settling, debounced status and sticky interrupt.
// Build option: define OV_HYST_EN to lower the trip code by HYST_CODES while tripped.
module overvoltage_ctrl
  import overvoltage_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 64,
  parameter int DEBOUNCE   = 4,
  parameter int HYST_CODES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_req,
  input  logic [OTRIP_W-1:0] otrip_cfg,
  input  logic               isrc_cfg,
  input  logic               ovout_async,
  input  logic               clr_irq,
  output logic               ena,
  output logic [OTRIP_W-1:0] otrip,
  output logic               isrc_sel,
  output logic               ready,
  output logic               ov_status,
  output logic               ov_irq
);

`ifdef OV_HYST_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif

  localparam int SCW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYC);

  localparam logic [1:0] ST_OFF     = OFF;
  localparam logic [1:0] ST_SETTLE  = SETTLE;
  localparam logic [1:0] ST_ARMED   = ARMED;
  localparam logic [1:0] ST_TRIPPED = TRIPPED;

  logic [1:0]         state, state_nxt;
  logic [SCW-1:0]     settle_cnt, settle_cnt_nxt;
  logic [OTRIP_W-1:0] otrip_app, otrip_app_nxt, otrip_drv;
  logic               isrc_app, isrc_app_nxt;
  logic               cfg_chg;
  logic               live;
  logic               blanking;
  logic               db_clr;
  logic               db_toggle;
  logic               ov_level;
  logic               irq_set;

  assign cfg_chg = (otrip_cfg != otrip_app) || (isrc_cfg != isrc_app);
  assign live    = (state == ST_ARMED) || (state == ST_TRIPPED);
  // In ARMED/TRIPPED a non-zero settle count only exists as hysteresis blanking.
  assign blanking = live && (settle_cnt != '0);
  assign db_clr   = !en_req || cfg_chg || !live || blanking;
  assign irq_set  = (state == ST_ARMED) && db_toggle;

  ov_sync_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_sync_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (ovout_async),
    .clr       (db_clr),
    .force_low (!en_req),
    .level     (ov_level),
    .toggle    (db_toggle)
  );

  assign ov_status = ov_level;

  // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    otrip_app_nxt  = otrip_app;
    isrc_app_nxt   = isrc_app;

    if (!en_req) begin
      state_nxt      = ST_OFF;
      settle_cnt_nxt = '0;
    end else if (state == ST_OFF || cfg_chg) begin
      otrip_app_nxt  = otrip_cfg;
      isrc_app_nxt   = isrc_cfg;
      settle_cnt_nxt = SETTLE_LOAD;
      state_nxt      = ST_SETTLE;
    end else if (state == ST_SETTLE) begin
      if (settle_cnt == SCW'(1)) begin
        state_nxt      = ov_level ? ST_TRIPPED : ST_ARMED;
        settle_cnt_nxt = (HYST_EN && ov_level) ? SETTLE_LOAD : '0;
      end else begin
        settle_cnt_nxt = settle_cnt - SCW'(1);
      end
    end else if (blanking) begin
      settle_cnt_nxt = settle_cnt - SCW'(1);
    end else if (db_toggle) begin
      state_nxt      = (state == ST_ARMED) ? ST_TRIPPED : ST_ARMED;
      settle_cnt_nxt = HYST_EN ? SETTLE_LOAD : '0;
    end
  end

  always_comb begin
    otrip_drv = otrip_app_nxt;
    if (HYST_EN && state_nxt == ST_TRIPPED) otrip_drv = sat_sub(otrip_app_nxt, HYST_CODES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      settle_cnt <= '0;
      otrip_app  <= '0;
      isrc_app   <= 1'b0;
      ena        <= 1'b0;
      otrip      <= '0;
      isrc_sel   <= 1'b0;
      ready      <= 1'b0;
      ov_irq     <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      otrip_app  <= otrip_app_nxt;
      isrc_app   <= isrc_app_nxt;
      ena        <= (state_nxt != ST_OFF);
      otrip      <= otrip_drv;
      isrc_sel   <= isrc_app_nxt;
      ready      <= (state_nxt == ST_ARMED) || (state_nxt == ST_TRIPPED);
      // A fresh trip outranks a coincident clear.
      if (irq_set)      ov_irq <= 1'b1;
      else if (clr_irq) ov_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_overvoltage_ctrl.sv
// Directed self-checking bench for overvoltage_ctrl (default parameters).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_overvoltage_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_req;
  logic [3:0] otrip_cfg;
  logic       isrc_cfg;
  logic       ovout_async;
  logic       clr_irq;
  logic       ena;
  logic [3:0] otrip;
  logic       isrc_sel;
  logic       ready;
  logic       ov_status;
  logic       ov_irq;

  int n_pass  = 0;
  int n_total = 0;

  overvoltage_ctrl #(
    .SETTLE_CYC (64),
    .DEBOUNCE   (4),
    .HYST_CODES (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_req      (en_req),
    .otrip_cfg   (otrip_cfg),
    .isrc_cfg    (isrc_cfg),
    .ovout_async (ovout_async),
    .clr_irq     (clr_irq),
    .ena         (ena),
    .otrip       (otrip),
    .isrc_sel    (isrc_sel),
    .ready       (ready),
    .ov_status   (ov_status),
    .ov_irq      (ov_irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs n edges expecting ready and ov_status to stay at the given values.
  task automatic hold_check(input string name, input int n, input logic exp_rdy, input logic exp_st);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ready !== exp_rdy || ov_status !== exp_st) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL %s: %0d of %0d cycles off (last ready=%b status=%b, want %b/%b)",
                           name, bad, n, ready, ov_status, exp_rdy, exp_st);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_req = 1'b0; otrip_cfg = 4'h0; isrc_cfg = 1'b0;
    ovout_async = 1'b0; clr_irq = 1'b0;
    tick(2);
    n_total++;
    if ({ena, otrip, isrc_sel, ready, ov_status, ov_irq} !== 9'h0)
      $display("FAIL reset_outs: got %b want 0", {ena, otrip, isrc_sel, ready, ov_status, ov_irq});
    else n_pass++;
    rst_n = 1'b1;
    en_req = 1'b1; otrip_cfg = 4'h3; isrc_cfg = 1'b1;
    tick();
    n_total++;
    if (ena !== 1'b1 || otrip !== 4'h3 || ready !== 1'b0)
      $display("FAIL settle_enter: got ena=%b otrip=%h ready=%b want 1/3/0", ena, otrip, ready);
    else n_pass++;
    tick(10);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({ena, otrip, isrc_sel, ready, ov_status, ov_irq} !== 9'h0)
      $display("FAIL reset_mid_settle: got %b want 0", {ena, otrip, isrc_sel, ready, ov_status, ov_irq});
    else n_pass++;
    en_req = 1'b0; isrc_cfg = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(3);
    n_total++;
    if (ena !== 1'b0 || ready !== 1'b0)
      $display("FAIL off_after_reset: got ena=%b ready=%b want 0/0", ena, ready);
    else n_pass++;
  endtask

  task automatic test_settle_trip();
    en_req = 1'b1; otrip_cfg = 4'h9; isrc_cfg = 1'b1; ovout_async = 1'b1;
    tick();
    n_total++;
    if (ena !== 1'b1 || otrip !== 4'h9 || isrc_sel !== 1'b1 || ready !== 1'b0)
      $display("FAIL enable: got ena=%b otrip=%h isrc=%b ready=%b want 1/9/1/0", ena, otrip, isrc_sel, ready);
    else n_pass++;
    hold_check("settle_blank", 63, 1'b0, 1'b0);
    tick();
    n_total++;
    if (ready !== 1'b1 || ov_status !== 1'b0)
      $display("FAIL armed_entry: got ready=%b status=%b want 1/0", ready, ov_status);
    else n_pass++;
    // ov_s is already high, so the count starts on the first ARMED edge.
    hold_check("armed_count", 3, 1'b1, 1'b0);
    tick();
    n_total++;
    if (ov_status !== 1'b1 || ov_irq !== 1'b1)
      $display("FAIL first_trip: got status=%b irq=%b want 1/1", ov_status, ov_irq);
    else n_pass++;
    // Release: 2 sync edges plus 4 debounce edges.
    ovout_async = 1'b0;
    hold_check("release_wait", 5, 1'b1, 1'b1);
    tick();
    n_total++;
    if (ov_status !== 1'b0 || ov_irq !== 1'b1)
      $display("FAIL release: got status=%b irq=%b want 0/1", ov_status, ov_irq);
    else n_pass++;
  endtask

  task automatic test_debounce();
    ovout_async = 1'b1;
    tick(3);
    ovout_async = 1'b0;
    hold_check("pulse3_reject", 8, 1'b1, 1'b0);
    ovout_async = 1'b1;
    hold_check("pulse4_wait", 5, 1'b1, 1'b0);
    tick();
    n_total++;
    if (ov_status !== 1'b1)
      $display("FAIL pulse4_trip: got status=%b want 1", ov_status);
    else n_pass++;
  endtask

  task automatic test_irq();
    clr_irq = 1'b1;
    tick();
    clr_irq = 1'b0;
    n_total++;
    if (ov_irq !== 1'b0 || ov_status !== 1'b1)
      $display("FAIL clr_alone: got irq=%b status=%b want 0/1", ov_irq, ov_status);
    else n_pass++;
    ovout_async = 1'b0;
    tick(6);
    n_total++;
    if (ov_status !== 1'b0)
      $display("FAIL rearm: got status=%b want 0", ov_status);
    else n_pass++;
    ovout_async = 1'b1;
    tick(5);
    clr_irq = 1'b1;
    tick();
    clr_irq = 1'b0;
    n_total++;
    if (ov_irq !== 1'b1 || ov_status !== 1'b1)
      $display("FAIL set_beats_clr: got irq=%b status=%b want 1/1", ov_irq, ov_status);
    else n_pass++;
    ovout_async = 1'b0;
    tick(6);
  endtask

  task automatic test_cfg_change();
    n_total++;
    if (ready !== 1'b1 || ov_status !== 1'b0)
      $display("FAIL cfg_pre: got ready=%b status=%b want 1/0", ready, ov_status);
    else n_pass++;
    otrip_cfg = 4'hA; ovout_async = 1'b1;
    tick();
    n_total++;
    if (otrip !== 4'hA || ready !== 1'b0 || ov_status !== 1'b0)
      $display("FAIL cfg_relatch: got otrip=%h ready=%b status=%b want a/0/0", otrip, ready, ov_status);
    else n_pass++;
    hold_check("cfg_settle", 63, 1'b0, 1'b0);
    tick();
    n_total++;
    if (ready !== 1'b1 || ov_status !== 1'b0)
      $display("FAIL cfg_rearm: got ready=%b status=%b want 1/0", ready, ov_status);
    else n_pass++;
    tick(4);
    n_total++;
    if (ov_status !== 1'b1 || otrip !== 4'hA)
      $display("FAIL cfg_trip: got status=%b otrip=%h want 1/a", ov_status, otrip);
    else n_pass++;
    // Source change from TRIPPED: back to settling, status held high.
    isrc_cfg = 1'b0;
    tick();
    n_total++;
    if (isrc_sel !== 1'b0 || ready !== 1'b0 || ov_status !== 1'b1)
      $display("FAIL isrc_change: got isrc=%b ready=%b status=%b want 0/0/1", isrc_sel, ready, ov_status);
    else n_pass++;
    hold_check("isrc_settle", 63, 1'b0, 1'b1);
    tick();
    n_total++;
    if (ready !== 1'b1 || ov_status !== 1'b1)
      $display("FAIL settle_to_tripped: got ready=%b status=%b want 1/1", ready, ov_status);
    else n_pass++;
  endtask

  task automatic test_disable();
    en_req = 1'b0; otrip_cfg = 4'h2;
    tick();
    n_total++;
    if (ena !== 1'b0 || ready !== 1'b0 || ov_status !== 1'b0 || ov_irq !== 1'b1 || otrip !== 4'hA)
      $display("FAIL disable: got ena=%b ready=%b status=%b irq=%b otrip=%h want 0/0/0/1/a",
               ena, ready, ov_status, ov_irq, otrip);
    else n_pass++;
    tick(3);
    n_total++;
    if (ena !== 1'b0 || ov_status !== 1'b0)
      $display("FAIL stay_off: got ena=%b status=%b want 0/0", ena, ov_status);
    else n_pass++;
  endtask

`ifdef OV_HYST_EN
  task automatic test_hyst();
    en_req = 1'b1; otrip_cfg = 4'h5; isrc_cfg = 1'b0; ovout_async = 1'b1;
    tick(65);
    tick(4);
    n_total++;
    if (ov_status !== 1'b1 || otrip !== 4'h4)
      $display("FAIL hyst_trip: got status=%b otrip=%h want 1/4", ov_status, otrip);
    else n_pass++;
    ovout_async = 1'b0;
    hold_check("hyst_blank", 67, 1'b1, 1'b1);
    tick();
    n_total++;
    if (ov_status !== 1'b0 || otrip !== 4'h5)
      $display("FAIL hyst_exit: got status=%b otrip=%h want 0/5", ov_status, otrip);
    else n_pass++;
    otrip_cfg = 4'h0; ovout_async = 1'b1;
    tick(65);
    tick(4);
    n_total++;
    if (ov_status !== 1'b1 || otrip !== 4'h0)
      $display("FAIL hyst_sat: got status=%b otrip=%h want 1/0", ov_status, otrip);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef OV_HYST_EN
    test_hyst();
`else
    test_settle_trip();
    test_debounce();
    test_irq();
    test_cfg_change();
    test_disable();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
